uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data bits per frame.
REQ-002 SHALL have parameter CLOCK, default 100e6, meaning clk_i frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 9600, meaning line bit rate.
REQ-004 SHALL have port clk_i  input  1  system clock, single clock domain.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port Rx  input  1  serial line, asynchronous, idle high.
REQ-007 SHALL have port cs  input  1  chip select from the peripheral bus decode.
REQ-008 SHALL have port re  input  1  read strobe; a read occurs on any cycle with cs=1 and re=1.
REQ-009 SHALL have port data_o  output  DW  holding register contents.
REQ-010 SHALL have port rx_valid  output  1  holding register has an unread byte.
REQ-011 SHALL have port frame_err  output  1  sticky, stop bit sampled low.
REQ-012 SHALL have port overrun  output  1  sticky, byte dropped while rx_valid=1.
REQ-013 SHALL have port parity_err  output  1  sticky, parity mismatch.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL define CPB = CLOCK/BAUD_RATE (integer division) and HALF = CPB/2; the baud counter SHALL be $clog2(CPB) bits wide.
REQ-016 SHALL pass Rx through a 2-flop synchronizer, preset to 1; all sampling SHALL use the synchronized value.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: a synchronized 1->0 transition SHALL move to START and clear the baud counter.
REQ-019 START: after HALF cycles, SHALL sample the line; a 0 moves to DATA, and a 1 (glitch) returns to IDLE with no flags set.
REQ-020 DATA: SHALL sample once every CPB cycles, shifting the bits in LSB first; after DW samples SHALL move to PARITY if the parity feature is compiled in, else to STOP.
REQ-021 PARITY: after CPB cycles, SHALL sample the parity bit and record a mismatch internally, then move to STOP.
REQ-022 STOP: after CPB cycles, SHALL sample the line and then return to IDLE.
REQ-023 Stop bit = 1, rx_valid=0: SHALL load the holding register, set rx_valid, and set parity_err if a mismatch was recorded, all on the same edge.
REQ-024 Stop bit = 0: SHALL set frame_err, SHALL NOT load the holding register, and SHALL NOT change rx_valid.
REQ-025 Stop bit = 1, rx_valid=1, no read in the same cycle: SHALL discard the new byte, keep the old data, and set overrun.
REQ-026 A read (cs=1, re=1) SHALL clear rx_valid, frame_err, overrun and parity_err on the next edge; data_o SHALL hold its value.
REQ-027 A read in the same cycle as a good stop sample: the load SHALL win, giving rx_valid=1 with the new data_o, and overrun SHALL NOT be set.
REQ-028 A read in the same cycle as a frame error: frame_err SHALL be 1 after the edge.
REQ-029 data_o and all flags SHALL be registered, with no combinational path from Rx or re.
REQ-030 Frame latency: rx_valid SHALL rise 2 + HALF + (DW+P)*CPB + CPB cycles, within 1 cycle, after Rx falls; P=1 with parity compiled in, else 0.
REQ-031 While busy=1, further falling edges on Rx SHALL be ignored.

Reset
REQ-032 rst_i SHALL force state IDLE and clear the baud counter, bit counter and shift register.
REQ-033 rst_i SHALL reset data_o=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0, busy=0 and both synchronizer flops to 1.
REQ-034 rst_i asserted mid-frame SHALL abort the frame with no flag set; after reset, reception SHALL resume on the next falling edge.

Configuration
REQ-035 Macro UART_RX_PARITY_EN defined: the frame SHALL include one even-parity bit after the data bits (REQ-021 active).
REQ-036 Macro UART_RX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, and parity_err SHALL be tied to 0.

Verification (CLOCK=160, BAUD_RATE=10, so CPB=16, DW=8)
REQ-037 Send 0xA5 with a good stop bit -> rx_valid=1, data_o=0xA5, all error flags 0; a read -> rx_valid=0 on the next cycle.
REQ-038 Drive a 4-cycle low pulse on an idle Rx -> back to IDLE, busy=0, rx_valid=0, no flags.
REQ-039 Send 0x3C with stop bit=0 -> frame_err=1, rx_valid=0, data_o unchanged.
REQ-040 Send 0x11 then 0x22 with no read -> data_o=0x11, overrun=1; repeat with the read coinciding with 0x22's stop sample -> data_o=0x22, overrun=0.
REQ-041 Assert rst_i during bit 4 of 0xFF -> all outputs 0; the next frame 0x5A is received correctly.
REQ-042 With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1, data_o=0x07.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, and a holding register with sticky error flags.
// Define UART_RX_PARITY_EN to add one even-parity bit after the data bits.
module uart_rx #(
  parameter int DW        = 8,
  parameter int CLOCK     = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          Rx,
  input  logic          cs,
  input  logic          re,
  output logic [DW-1:0] data_o,
  output logic          rx_valid,
  output logic          frame_err,
  output logic          overrun,
  output logic          parity_err,
  output logic          busy
);

  localparam int CPB  = CLOCK / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int BW   = $clog2(DW + 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic            rx_prev_q, rx_prev_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic [DW-1:0]   data_q, data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            busy_q, busy_d;
  logic            rx_s;
  logic            rd_req;
`ifdef UART_RX_PARITY_EN
  logic            parity_err_q, parity_err_d;
  logic            par_bad_q, par_bad_d;
`endif

  assign rx_s   = sync_q[1];
  assign rd_req = cs & re;

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], Rx};
    rx_prev_d   = rx_s;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
    par_bad_d    = par_bad_q;
`endif

    // A read clears the flags first so that a same-cycle stop sample can still set them.
    if (rd_req) begin
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end

    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d            = '0;
          shift_d          = shift_q >> 1;
          shift_d[DW-1]    = rx_s;
          if (bit_cnt_q == BW'(DW - 1)) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d     = '0;
          par_bad_d = (^shift_q) ^ rx_s;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end else if (!rx_valid_q || rd_req) begin
            data_d     = shift_q;
            rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) parity_err_d = 1'b1;
`endif
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      rx_prev_q   <= 1'b1;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rx_prev_q   <= rx_prev_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
      par_bad_q    <= par_bad_d;
`endif
    end
  end

  assign data_o    = data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames against a frame-level behavioural model.
module tb_uart_rx;

  localparam int DW   = 8;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB      = DW + P + 2;
  localparam int LAT     = 2 + HALF + (DW + P) * CPB + CPB;
  localparam int STOPIDX = 2 + HALF + (DW + P + 1) * CPB;

  logic          clk = 1'b0;
  logic          rst_i, Rx, cs, re;
  logic [DW-1:0] data_o;
  logic          rx_valid, frame_err, overrun, parity_err, busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_data;
  logic       m_valid, m_ferr, m_ovr, m_perr;

  uart_rx #(.DW(DW), .CLOCK(160), .BAUD_RATE(10)) dut (
    .clk_i(clk), .rst_i(rst_i), .Rx(Rx), .cs(cs), .re(re),
    .data_o(data_o), .rx_valid(rx_valid), .frame_err(frame_err),
    .overrun(overrun), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".data_o"},     32'(data_o),     32'(m_data));
    checkValue({tag, ".rx_valid"},   32'(rx_valid),   32'(m_valid));
    checkValue({tag, ".frame_err"},  32'(frame_err),  32'(m_ferr));
    checkValue({tag, ".overrun"},    32'(overrun),    32'(m_ovr));
    checkValue({tag, ".parity_err"}, 32'(parity_err), 32'(m_perr));
    checkValue({tag, ".busy"},       32'(busy),       32'(0));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
    m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
  endtask

  task automatic doRead();
    cs = 1'b1; re = 1'b1;
    tick(1);
    cs = 1'b0; re = 1'b0;
    m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
  endtask

  // Model of what one complete frame does to the holding register and flags at its stop sample.
  task automatic modelStop(input logic [7:0] d, input logic stop, input logic flip, input logic rd);
    logic old_valid;
    old_valid = m_valid;
    if (rd) begin
      m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    end
    if (!stop) m_ferr = 1'b1;
    else if (!old_valid || rd) begin
      m_data  = d;
      m_valid = 1'b1;
      if (P == 1 && flip) m_perr = 1'b1;
    end else m_ovr = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic stop, input logic flip,
                               input logic rd, input logic chk_lat);
    logic bits [0:NB-1];
    int   rise;
    logic prev;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1 + i] = d[i];
    if (P == 1) bits[DW + 1] = (^d) ^ flip;
    bits[NB - 1] = stop;
    rise = -1;
    prev = rx_valid;
    Rx = bits[0];
    for (int c = 0; c < NB * CPB - 1; c++) begin
      @(posedge clk);
      #1;
      if (!prev && rx_valid && rise < 0) rise = c;
      prev = rx_valid;
      if (c == 60) checkValue("busy_mid_frame", 32'(busy), 32'(1));
      Rx = bits[(c + 1) / CPB];
      cs = (rd && (c + 1 == STOPIDX));
      re = cs;
    end
    tick(1);
    Rx = 1'b1; cs = 1'b0; re = 1'b0;
    modelStop(d, stop, flip, rd);
    if (chk_lat) begin
      checks++;
      assert (rise >= LAT - 1 && rise <= LAT + 1) else begin
        errors++;
        $error("[TB] FAIL latency: observed=%0d expected=%0d+-1", rise, LAT);
      end
    end
    tick(6);
  endtask

  initial begin
    logic [7:0] d;
    logic       stop, flip, rd;
    rst_i = 1'b1; Rx = 1'b1; cs = 1'b0; re = 1'b0;
    tick(3);
    doReset();
    checkOutput("reset");

    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("a5");
    doRead();
    checkOutput("a5_read");

    Rx = 1'b0;
    tick(4);
    Rx = 1'b1;
    tick(24);
    checkOutput("glitch");

    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("frame_err");
    doRead();
    checkOutput("frame_err_read");

    applyStimulus(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("overrun");
    doRead();
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("read_at_stop");
    doRead();

`ifdef UART_RX_PARITY_EN
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("parity_ok");
    doRead();
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("parity_bad");
    doRead();
`endif

    // Reset lands in the middle of data bit 4 of an all-ones byte.
    Rx = 1'b0;
    tick(CPB);
    Rx = 1'b1;
    tick(4 * CPB + HALF);
    doReset();
    checkOutput("mid_reset");
    tick(4);
    applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("after_reset");
    doRead();

    for (int k = 0; k < 12; k++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      flip = 1'($urandom_range(0, 1));
      rd   = ($urandom_range(0, 3) == 0);
      applyStimulus(d, stop, flip, rd, 1'b0);
      checkOutput("random");
      if ($urandom_range(0, 1) == 1) begin
        doRead();
        checkOutput("random_read");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
